// File: rtl/rgb_pkg.sv
// Shared types and constants for the rgb pixel source: input FSM states,
// the buffered pixel word layout and coordinate width helpers.
package rgb_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCEPT   = 1'b1
  } in_state_t;

  localparam int DEF_COLOR_BITS = 8;
  localparam int DEF_X_WIDTH    = 64;
  localparam int DEF_Y_WIDTH    = 64;

  // Buffered word layout at the default colour depth; modules with other
  // depths declare the same {sof, color} shape locally.
  typedef struct packed {
    logic                          sof;
    logic [3*DEF_COLOR_BITS-1:0]   color;
  } pixel_t;

  function automatic int coord_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_X_BITS = coord_bits(DEF_X_WIDTH);
  localparam int DEF_Y_BITS = coord_bits(DEF_Y_WIDTH);

endpackage

// File: rtl/rgb_pixel_source_if.sv
// Host pixel stream plus tagged pixel stream towards the rgb stage.
// master = the pixel source block, slave = its surroundings (host + rgb stage).
interface rgb_pixel_source_if #(
  parameter int COLOR_BITS = 8,
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 6
);
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_sof;
  logic [3*COLOR_BITS-1:0] s_color;

  logic                    m_valid;
  logic                    m_ready;
  logic [X_BITS-1:0]       x;
  logic [Y_BITS-1:0]       y;
  logic [3*COLOR_BITS-1:0] color;
  logic                    m_eol;
  logic                    m_eof;

  modport master (
    input  s_valid, s_sof, s_color, m_ready,
    output s_ready, m_valid, x, y, color, m_eol, m_eof
  );

  modport slave (
    output s_valid, s_sof, s_color, m_ready,
    input  s_ready, m_valid, x, y, color, m_eol, m_eof
  );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered full flag and occupancy count.
// The head word is read straight from the array, so a push is visible next cycle.
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & ~full_q & ~clr;
    do_pop   = pop & (level_q != '0) & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    // Full is registered so the host-side ready never depends on this cycle's pop.
    full_d = (level_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/rgb_pixel_source.sv
// Buffers a host pixel stream, tags each pixel with raster x/y and presents
// it to the rgb stage; resynchronises the raster position on start-of-frame.
module rgb_pixel_source
  import rgb_pkg::*;
#(
  parameter int X_WIDTH    = DEF_X_WIDTH,
  parameter int Y_WIDTH    = DEF_Y_WIDTH,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  rgb_pixel_source_if.master          bus,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int XB = coord_bits(X_WIDTH);
  localparam int YB = coord_bits(Y_WIDTH);

  typedef struct packed {
    logic                    sof;
    logic [3*COLOR_BITS-1:0] color;
  } word_t;

  in_state_t     state_q, state_d;
  logic [XB-1:0] cx_q, cx_d, x_cur;
  logic [YB-1:0] cy_q, cy_d, y_cur;
  logic          out_en_q;
  logic          err_seen_q, err_seen_d;
  logic          done_q, done_d;
  logic          fifo_full, fifo_empty, fifo_push, pop, s_accept, m_valid_int;
  logic          eol, eof, err_now;
  word_t         head, wr_word;

  // Holds s_ready low until the first edge after reset is released.
  assign bus.s_ready = out_en_q & ~fifo_full;

  always_comb begin
    s_accept    = bus.s_valid & bus.s_ready;
    wr_word     = {bus.s_sof, bus.s_color};
    m_valid_int = ~fifo_empty;
    pop         = m_valid_int & bus.m_ready & ~flush;
    x_cur       = head.sof ? '0 : cx_q;
    y_cur       = head.sof ? '0 : cy_q;
    eol         = (x_cur == XB'(X_WIDTH - 1));
    eof         = eol & (y_cur == YB'(Y_WIDTH - 1));
    err_now     = m_valid_int & head.sof & ((cx_q != '0) | (cy_q != '0)) & ~err_seen_q;

    state_d   = state_q;
    fifo_push = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (s_accept & bus.s_sof) begin
          fifo_push = 1'b1;
          state_d   = ACCEPT;
        end
      end
      ACCEPT:   fifo_push = s_accept;
      default:  state_d = WAIT_SOF;
    endcase

    cx_d = cx_q;
    cy_d = cy_q;
    if (pop) begin
      if (x_cur != XB'(X_WIDTH - 1)) begin
        cx_d = x_cur + 1'b1;
        cy_d = y_cur;
      end else begin
        cx_d = '0;
        cy_d = (y_cur == YB'(Y_WIDTH - 1)) ? '0 : y_cur + 1'b1;
      end
    end

    // A misaligned head flags once; the flag re-arms when that head leaves.
    err_seen_d = pop ? 1'b0 : (err_seen_q | err_now);
    done_d     = pop & eof;

    if (flush) begin
      state_d    = WAIT_SOF;
      fifo_push  = 1'b0;
      cx_d       = '0;
      cy_d       = '0;
      err_seen_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_SOF;
      cx_q       <= '0;
      cy_q       <= '0;
      out_en_q   <= 1'b0;
      err_seen_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      out_en_q   <= 1'b1;
      err_seen_q <= err_seen_d;
      done_q     <= done_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (flush),
    .push  (fifo_push),
    .pop   (pop),
    .wdata (wr_word),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign bus.m_valid = m_valid_int;
  assign bus.x       = m_valid_int ? x_cur : '0;
  assign bus.y       = m_valid_int ? y_cur : '0;
  assign bus.color   = m_valid_int ? head.color : '0;
  assign bus.m_eol   = m_valid_int & eol;
  assign bus.m_eof   = m_valid_int & eof;
  assign frame_err   = err_now;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_rgb_pixel_source.sv
// Randomised bench for rgb_pixel_source against a queue + linear-raster-index model.
module tb_rgb_pixel_source;
  localparam int X_W   = 6;
  localparam int Y_W   = 4;
  localparam int CB    = 8;
  localparam int DEPTH = 16;
  localparam int XB    = $clog2(X_W);
  localparam int YB    = $clog2(Y_W);
  localparam int CW    = 3 * CB;
  localparam int LB    = $clog2(DEPTH) + 1;
  localparam int FRAME = X_W * Y_W;

  typedef struct packed {
    logic          sof;
    logic [CW-1:0] color;
  } tpix_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          frame_done, frame_err;
  logic [LB-1:0] level;

  rgb_pixel_source_if #(.COLOR_BITS(CB), .X_BITS(XB), .Y_BITS(YB)) bus ();

  rgb_pixel_source #(
    .X_WIDTH(X_W), .Y_WIDTH(Y_W), .COLOR_BITS(CB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .frame_done(frame_done), .frame_err(frame_err), .level(level)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: queue of buffered words, raster position as a linear index.
  tpix_t mq[$];
  int    mpos;
  bit    m_sync, m_en, m_done, m_err_shown;

  bit            exp_valid, exp_ready, exp_eol, exp_eof, exp_done, exp_err;
  logic [XB-1:0] exp_x;
  logic [YB-1:0] exp_y;
  logic [CW-1:0] exp_color;
  int            exp_level;

  task automatic model_reset();
    mq.delete();
    mpos = 0; m_sync = 0; m_en = 0; m_done = 0; m_err_shown = 0;
  endtask

  task automatic predict();
    int pos;
    exp_valid = (mq.size() != 0);
    exp_ready = m_en && (mq.size() < DEPTH);
    exp_level = mq.size();
    exp_done  = m_done;
    exp_err = 0; exp_x = '0; exp_y = '0; exp_color = '0; exp_eol = 0; exp_eof = 0;
    if (exp_valid) begin
      pos       = mq[0].sof ? 0 : mpos;
      exp_x     = XB'(pos % X_W);
      exp_y     = YB'(pos / X_W);
      exp_color = mq[0].color;
      exp_eol   = (pos % X_W) == X_W - 1;
      exp_eof   = (pos == FRAME - 1);
      if (mq[0].sof && mpos != 0 && !m_err_shown) begin
        exp_err = 1;
        m_err_shown = 1;
      end
    end
  endtask

  task automatic advance(input bit sv, input bit sof, input logic [CW-1:0] col,
                         input bit mr, input bit fl);
    int pos;
    bus.s_valid = sv; bus.s_sof = sof; bus.s_color = col; bus.m_ready = mr; flush = fl;
    m_done = 0;
    if (fl) begin
      mq.delete(); mpos = 0; m_sync = 0; m_err_shown = 0;
    end else begin
      if (exp_valid && mr) begin
        pos    = mq[0].sof ? 0 : mpos;
        m_done = (pos == FRAME - 1);
        mpos   = (pos + 1) % FRAME;
        void'(mq.pop_front());
        m_err_shown = 0;
      end
      if (sv && exp_ready && (m_sync || sof)) begin
        mq.push_back({sof, col});
        m_sync = 1;
      end
    end
    m_en = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_color = '0; bus.m_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_total++; if (bus.s_ready !== 1'b0) $display("FAIL reset s_ready: got %b want 0", bus.s_ready); else n_pass++;
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL reset m_valid: got %b want 0", bus.m_valid); else n_pass++;
    n_total++; if (level !== '0) $display("FAIL reset level: got %0d want 0", level); else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b want 0", frame_done); else n_pass++;
    reset = 1'b1;
    predict();
    n_total++; if (bus.s_ready !== exp_ready) $display("FAIL release s_ready: got %b want %b", bus.s_ready, exp_ready); else n_pass++;
    advance(0, 0, '0, 0, 0);
    predict();
    n_total++; if (bus.s_ready !== exp_ready) $display("FAIL ready_up s_ready: got %b want %b", bus.s_ready, exp_ready); else n_pass++;
    advance(0, 0, '0, 0, 0);
  endtask

  // Three stray beats before sof, then one full frame with the sink always ready.
  task automatic test_frame();
    for (int i = 0; i < 3 + FRAME + 2; i++) begin
      predict();
      n_total++; if (bus.m_valid !== exp_valid) $display("FAIL frame m_valid[%0d]: got %b want %b", i, bus.m_valid, exp_valid); else n_pass++;
      n_total++; if (bus.x !== exp_x) $display("FAIL frame x[%0d]: got %0d want %0d", i, bus.x, exp_x); else n_pass++;
      n_total++; if (bus.y !== exp_y) $display("FAIL frame y[%0d]: got %0d want %0d", i, bus.y, exp_y); else n_pass++;
      n_total++; if (bus.color !== exp_color) $display("FAIL frame color[%0d]: got %h want %h", i, bus.color, exp_color); else n_pass++;
      n_total++; if (level !== LB'(exp_level)) $display("FAIL frame level[%0d]: got %0d want %0d", i, level, exp_level); else n_pass++;
      n_total++; if (bus.m_eol !== exp_eol) $display("FAIL frame m_eol[%0d]: got %b want %b", i, bus.m_eol, exp_eol); else n_pass++;
      n_total++; if (bus.m_eof !== exp_eof) $display("FAIL frame m_eof[%0d]: got %b want %b", i, bus.m_eof, exp_eof); else n_pass++;
      n_total++; if (frame_done !== exp_done) $display("FAIL frame frame_done[%0d]: got %b want %b", i, frame_done, exp_done); else n_pass++;
      advance(i < 3 + FRAME, i == 3, CW'($urandom), 1'b1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 40; i++) begin
      predict();
      n_total++; if (bus.s_ready !== exp_ready) $display("FAIL bp s_ready[%0d]: got %b want %b", i, bus.s_ready, exp_ready); else n_pass++;
      n_total++; if (level !== LB'(exp_level)) $display("FAIL bp level[%0d]: got %0d want %0d", i, level, exp_level); else n_pass++;
      n_total++; if (bus.m_valid !== exp_valid) $display("FAIL bp m_valid[%0d]: got %b want %b", i, bus.m_valid, exp_valid); else n_pass++;
      n_total++; if (bus.color !== exp_color) $display("FAIL bp color[%0d]: got %h want %h", i, bus.color, exp_color); else n_pass++;
      n_total++; if (bus.x !== exp_x) $display("FAIL bp x[%0d]: got %0d want %0d", i, bus.x, exp_x); else n_pass++;
      advance(i < 20, 1'b0, CW'($urandom), i >= 20, 1'b0);
    end
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 16; i++) begin
      predict();
      n_total++; if (frame_err !== exp_err) $display("FAIL misalign frame_err[%0d]: got %b want %b", i, frame_err, exp_err); else n_pass++;
      n_total++; if (bus.x !== exp_x) $display("FAIL misalign x[%0d]: got %0d want %0d", i, bus.x, exp_x); else n_pass++;
      n_total++; if (bus.y !== exp_y) $display("FAIL misalign y[%0d]: got %0d want %0d", i, bus.y, exp_y); else n_pass++;
      // Sink stalls for a few cycles while the sof pixel is at the head.
      advance(i < 13, i == 9, CW'($urandom), !(i >= 10 && i <= 12), 1'b0);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 18; i++) begin
      predict();
      n_total++; if (bus.m_valid !== exp_valid) $display("FAIL flush m_valid[%0d]: got %b want %b", i, bus.m_valid, exp_valid); else n_pass++;
      n_total++; if (level !== LB'(exp_level)) $display("FAIL flush level[%0d]: got %0d want %0d", i, level, exp_level); else n_pass++;
      n_total++; if (bus.s_ready !== exp_ready) $display("FAIL flush s_ready[%0d]: got %b want %b", i, bus.s_ready, exp_ready); else n_pass++;
      n_total++; if (bus.x !== exp_x) $display("FAIL flush x[%0d]: got %0d want %0d", i, bus.x, exp_x); else n_pass++;
      // 7 beats stall, flush with a beat offered, stray beats, then a new sof.
      advance(i != 8 && i < 15, i == 12, CW'($urandom), i > 7, i == 7);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      predict();
      advance(1'b1, 1'b0, CW'($urandom), 1'b0, 1'b0);
    end
    #2 reset = 1'b0;
    #1;
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL areset m_valid: got %b want 0", bus.m_valid); else n_pass++;
    n_total++; if (level !== '0) $display("FAIL areset level: got %0d want 0", level); else n_pass++;
    n_total++; if (bus.s_ready !== 1'b0) $display("FAIL areset s_ready: got %b want 0", bus.s_ready); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      predict();
      n_total++; if (bus.m_valid !== exp_valid) $display("FAIL resync m_valid[%0d]: got %b want %b", i, bus.m_valid, exp_valid); else n_pass++;
      n_total++; if (level !== LB'(exp_level)) $display("FAIL resync level[%0d]: got %0d want %0d", i, level, exp_level); else n_pass++;
      n_total++; if (bus.x !== exp_x) $display("FAIL resync x[%0d]: got %0d want %0d", i, bus.x, exp_x); else n_pass++;
      advance(1'b1, i == 4, CW'($urandom), 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    bit sv, sof, mr, fl;
    for (int i = 0; i < 600; i++) begin
      predict();
      n_total++; if (bus.m_valid !== exp_valid) $display("FAIL rand m_valid[%0d]: got %b want %b", i, bus.m_valid, exp_valid); else n_pass++;
      n_total++; if (bus.s_ready !== exp_ready) $display("FAIL rand s_ready[%0d]: got %b want %b", i, bus.s_ready, exp_ready); else n_pass++;
      n_total++; if (level !== LB'(exp_level)) $display("FAIL rand level[%0d]: got %0d want %0d", i, level, exp_level); else n_pass++;
      n_total++; if (bus.x !== exp_x) $display("FAIL rand x[%0d]: got %0d want %0d", i, bus.x, exp_x); else n_pass++;
      n_total++; if (bus.y !== exp_y) $display("FAIL rand y[%0d]: got %0d want %0d", i, bus.y, exp_y); else n_pass++;
      n_total++; if (bus.color !== exp_color) $display("FAIL rand color[%0d]: got %h want %h", i, bus.color, exp_color); else n_pass++;
      n_total++; if (bus.m_eol !== exp_eol) $display("FAIL rand m_eol[%0d]: got %b want %b", i, bus.m_eol, exp_eol); else n_pass++;
      n_total++; if (bus.m_eof !== exp_eof) $display("FAIL rand m_eof[%0d]: got %b want %b", i, bus.m_eof, exp_eof); else n_pass++;
      n_total++; if (frame_done !== exp_done) $display("FAIL rand frame_done[%0d]: got %b want %b", i, frame_done, exp_done); else n_pass++;
      n_total++; if (frame_err !== exp_err) $display("FAIL rand frame_err[%0d]: got %b want %b", i, frame_err, exp_err); else n_pass++;
      sv  = ($urandom_range(0, 3) != 0);
      sof = ($urandom_range(0, 39) == 0);
      mr  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 199) == 0);
      advance(sv, sof, CW'($urandom), mr, fl);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_misaligned();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
